immgen_pipe: RTL and testbench

//  Registered, flow-controlled successor to the combinational immediate generator.

---
 rtl/immgen_pipe_if.sv | 30 +++
 rtl/immgen_pipe.sv | 183 ++++++++++++++++++
 tb/tb_immgen_pipe.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/immgen_pipe_if.sv
// Handshake bundle for immgen_pipe: fetch-side word/tag input and decode-side result output.
// master = producer/consumer environment, slave = the immediate-generator pipe itself.
interface immgen_pipe_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 8
);
    // Fetch side
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_inst;
    logic [TAG_W-1:0] in_tag;

    // Decode side
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic [2:0]       out_fmt;
    logic             out_illegal;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_inst, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
    );

    modport slave (
        input  in_valid, in_inst, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
    );
endinterface

// File: rtl/immgen_pipe.sv
// Registered immediate generator for RV32I/RV64I instruction words.
// Each accepted word is decoded into {imm, fmt, illegal} and buffered, with its tag, in a
// 2-entry skid FIFO. The head entry register drives the outputs directly, so there is no
// combinational path from the input side to the output side, and in_ready only depends on
// registered occupancy.
module immgen_pipe #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 8
) (
    input logic          clk,
    input logic          rst,
    input logic          flush,
    immgen_pipe_if.slave bus
);

    // Format codes presented on out_fmt
    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;

    // Occupancy states
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [2:0]       fmt;
        logic             illegal;
        logic [TAG_W-1:0] tag;
    } entry_t;

    localparam entry_t ENTRY_ZERO = '0;

    logic [1:0] state_q, state_d;
    entry_t     head_q, head_d;
    entry_t     tail_q, tail_d;
    entry_t     dec;

    logic       push;
    logic       pop;

    // Decode one instruction word into a buffer entry
    function automatic entry_t decode(input logic [31:0] inst, input logic [TAG_W-1:0] tag);
        entry_t             e;
        logic signed [31:0] imm32;
        logic [2:0]         fmt;
        logic               bad;

        imm32 = '0;
        fmt   = FMT_NONE;
        bad   = 1'b0;

        unique case (inst[6:2])
            // LOAD, LOAD-FP, OP-IMM, JALR, SYSTEM
            5'b00000, 5'b00001, 5'b00011, 5'b00100, 5'b11001, 5'b11100: begin
                fmt = FMT_I;
            end
            // OP-IMM-32 exists only on RV64
            5'b00110: begin
                if (XLEN == 64) begin
                    fmt = FMT_I;
                end else begin
                    bad = 1'b1;
                end
            end
            // STORE, STORE-FP
            5'b01000, 5'b01001: fmt = FMT_S;
            5'b11000:           fmt = FMT_B;
            5'b11011:           fmt = FMT_J;
            // AUIPC, LUI
            5'b00101, 5'b01101: fmt = FMT_U;
            default:            bad = 1'b1;
        endcase

        // 16-bit compressed encodings are not handled here
        if (inst[1:0] != 2'b11) begin
            bad = 1'b1;
        end

        unique case (fmt)
            FMT_I:   imm32 = {{20{inst[31]}}, inst[31:20]};
            FMT_S:   imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            FMT_B:   imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            FMT_U:   imm32 = {inst[31:12], 12'b0};
            FMT_J:   imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21],
                              1'b0};
            default: imm32 = '0;
        endcase

        if (bad) begin
            imm32 = '0;
            fmt   = FMT_NONE;
        end

        // Sign-extending size cast covers both XLEN=32 and XLEN=64
        e.imm     = XLEN'(imm32);
        e.fmt     = fmt;
        e.illegal = bad;
        e.tag     = tag;
        return e;
    endfunction

    // Decode the incoming word; only captured when it is pushed
    always_comb begin
        dec = decode(bus.in_inst, bus.in_tag);
    end

    // Handshake qualifiers; flush squashes both sides
    always_comb begin
        push = bus.in_valid & (state_q != ST_TWO) & ~flush;
        pop  = (state_q != ST_EMPTY) & bus.out_ready & ~flush;
    end

    // Occupancy FSM and entry movement
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;

        if (flush) begin
            // Data registers may keep stale contents; only occupancy matters
            state_d = ST_EMPTY;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (push) begin
                        head_d  = dec;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (push && pop) begin
                        // Head leaves, new word takes its place
                        head_d = dec;
                    end else if (push) begin
                        tail_d  = dec;
                        state_d = ST_TWO;
                    end else if (pop) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    // in_ready is low here, so push cannot occur
                    if (pop) begin
                        head_d  = tail_q;
                        state_d = ST_ONE;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // State and entry registers; reset also clears the visible output payload
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            head_q  <= ENTRY_ZERO;
            tail_q  <= ENTRY_ZERO;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    // Outputs come straight from registers
    always_comb begin
        bus.in_ready    = (state_q != ST_TWO);
        bus.out_valid   = (state_q != ST_EMPTY);
        bus.out_imm     = head_q.imm;
        bus.out_fmt     = head_q.fmt;
        bus.out_illegal = head_q.illegal;
        bus.out_tag     = head_q.tag;
    end

endmodule

// File: tb/tb_immgen_pipe.sv
// Bench for immgen_pipe (XLEN=64): directed words with hand-computed results, a scoreboard
// queue filled when a word is accepted, and a monitor that checks every delivered entry.
module tb_immgen_pipe;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned TAG_W = 8;
    localparam int          BOUND = 50;

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
        logic [7:0]  tag;
    } exp_t;

    logic clk;
    logic rst;
    logic flush;

    immgen_pipe_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

    immgen_pipe #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    exp_t sb[$];
    int   total   = 0;
    int   bad     = 0;
    int   pop_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s act=%h req=%h", name, act, req);
        end
    endtask

    // Monitor: every accepted output must match the oldest expected entry
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && !flush && bus.out_valid && bus.out_ready) begin
                pop_cnt++;
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out act_tag=%h req=none", bus.out_tag);
                end else begin
                    e = sb.pop_front();
                    chk("out_imm", bus.out_imm, e.imm);
                    chk("out_fmt", 64'(bus.out_fmt), 64'(e.fmt));
                    chk("out_illegal", 64'(bus.out_illegal), 64'(e.ill));
                    chk("out_tag", 64'(bus.out_tag), 64'(e.tag));
                end
            end
        end
    end

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog act=timeout req=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a word until accepted; the expected entry is queued at the accepting edge
    task automatic send(input logic [31:0] inst, input logic [7:0] tag, input logic [63:0] imm,
                        input logic [2:0] fmt, input logic ill, output int waits);
        exp_t e;
        e.imm = imm;
        e.fmt = fmt;
        e.ill = ill;
        e.tag = tag;
        bus.in_valid = 1'b1;
        bus.in_inst  = inst;
        bus.in_tag   = tag;
        waits = 0;
        forever begin
            @(negedge clk);
            if (bus.in_ready) begin
                sb.push_back(e);
                tick();
                break;
            end
            waits++;
            if (waits >= BOUND) begin
                total++;
                bad++;
                $display("FAIL send_timeout act=%0d req=<%0d", waits, BOUND);
                break;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    initial begin
        int w;
        int p0;

        rst           = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_inst   = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_out_imm", bus.out_imm, 64'd0);
        chk("rst_out_fmt", 64'(bus.out_fmt), 64'd0);
        chk("rst_out_illegal", 64'(bus.out_illegal), 64'd0);
        chk("rst_out_tag", 64'(bus.out_tag), 64'd0);

        // 1: addi x1,x0,5 -> visible right after the accepting edge
        bus.out_ready = 1'b1;
        send(32'h00500093, 8'h10, 64'd5, 3'd1, 1'b0, w);
        chk("latency_valid", 64'(bus.out_valid), 64'd1);
        chk("latency_imm", bus.out_imm, 64'd5);
        tick();

        // 2: beq offset -4, lui 0x80000
        send(32'hFE000EE3, 8'h20, 64'hFFFF_FFFF_FFFF_FFFC, 3'd3, 1'b0, w);
        send(32'h800000B7, 8'h21, 64'hFFFF_FFFF_8000_0000, 3'd4, 1'b0, w);
        repeat (2) tick();

        // 3: stall with 3 words queued behind a blocked consumer
        bus.out_ready = 1'b0;
        send(32'h00500093, 8'd1, 64'd5, 3'd1, 1'b0, w);
        send(32'hFFF00093, 8'd2, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0, w);
        bus.in_valid = 1'b1;
        bus.in_inst  = 32'h0020A423;
        bus.in_tag   = 8'd3;
        chk("full_in_ready", 64'(bus.in_ready), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_valid", 64'(bus.out_valid), 64'd1);
            chk("stall_tag", 64'(bus.out_tag), 64'd1);
            chk("stall_imm", bus.out_imm, 64'd5);
            chk("stall_fmt", 64'(bus.out_fmt), 64'd1);
            chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
        end
        bus.out_ready = 1'b1;
        send(32'h0020A423, 8'd3, 64'd8, 3'd2, 1'b0, w);
        repeat (3) tick();
        chk("drain3_empty", 64'(bus.out_valid), 64'd0);

        // 4: back-to-back streaming, one word per cycle
        p0 = pop_cnt;
        send(32'h008000EF, 8'h40, 64'd8, 3'd5, 1'b0, w);
        chk("tput_wait", 64'(w), 64'd0);
        send(32'h00001097, 8'h41, 64'h1000, 3'd4, 1'b0, w);
        chk("tput_wait", 64'(w), 64'd0);
        send(32'h01013083, 8'h42, 64'd16, 3'd1, 1'b0, w);
        chk("tput_wait", 64'(w), 64'd0);
        send(32'h0030809B, 8'h43, 64'd3, 3'd1, 1'b0, w);
        chk("tput_wait", 64'(w), 64'd0);
        send(32'h00008067, 8'h44, 64'd0, 3'd1, 1'b0, w);
        chk("tput_wait", 64'(w), 64'd0);
        send(32'h00412087, 8'h45, 64'd4, 3'd1, 1'b0, w);
        chk("tput_wait", 64'(w), 64'd0);
        send(32'h00112227, 8'h46, 64'd4, 3'd2, 1'b0, w);
        chk("tput_wait", 64'(w), 64'd0);
        send(32'h00000463, 8'h47, 64'd8, 3'd3, 1'b0, w);
        chk("tput_wait", 64'(w), 64'd0);
        tick();
        chk("tput_pops", 64'(pop_cnt - p0), 64'd8);

        // 5: compressed-space and unknown opcode still delivered as illegal
        send(32'h00000010, 8'h50, 64'd0, 3'd0, 1'b1, w);
        send(32'h0000000B, 8'h51, 64'd0, 3'd0, 1'b1, w);
        send(32'h12345037, 8'h52, 64'h1234_5000, 3'd4, 1'b0, w);
        repeat (3) tick();

        // 6: flush while full, with a same-cycle input and consumer ready
        bus.out_ready = 1'b0;
        send(32'h00500093, 8'h61, 64'd5, 3'd1, 1'b0, w);
        send(32'h00500093, 8'h62, 64'd5, 3'd1, 1'b0, w);
        chk("pre_flush_ready", 64'(bus.in_ready), 64'd0);
        flush         = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_inst   = 32'h800000B7;
        bus.in_tag    = 8'h63;
        bus.out_ready = 1'b1;
        tick();
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        sb.delete();
        chk("flush_valid", 64'(bus.out_valid), 64'd0);
        chk("flush_ready", 64'(bus.in_ready), 64'd1);
        repeat (3) tick();
        chk("flush_no_ghost", 64'(bus.out_valid), 64'd0);

        // Reset mid-stream discards both entries and clears the payload
        bus.out_ready = 1'b0;
        send(32'hFFF00093, 8'h71, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0, w);
        send(32'h0000000B, 8'h72, 64'd0, 3'd0, 1'b1, w);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        chk("rst2_valid", 64'(bus.out_valid), 64'd0);
        chk("rst2_ready", 64'(bus.in_ready), 64'd1);
        chk("rst2_imm", bus.out_imm, 64'd0);
        chk("rst2_tag", 64'(bus.out_tag), 64'd0);
        bus.out_ready = 1'b1;
        send(32'hFE000EE3, 8'h73, 64'hFFFF_FFFF_FFFF_FFFC, 3'd3, 1'b0, w);
        chk("rst2_latency", 64'(bus.out_valid), 64'd1);

        // Drain remaining expectations
        for (int i = 0; i < BOUND && sb.size() != 0; i++) begin
            tick();
        end
        chk("drain_left", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
